// File: rtl/ram_ctrl.sv
// Word-addressed on-chip RAM behind a level-request / done-pulse handshake.
// Each access takes WAIT_CYCLES+2 edges from accept to done; new requests are sampled only in IDLE.
module ram_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ctrl_in,
  output logic [31:0] ctrl_out,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR, OP_ERR} op_t;

  state_t      state_q;
  op_t         op_q;
  op_t         op_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rd_data_q;
  logic        ready_q;
  logic        done_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic          in_range;
  logic          access;
  logic          mem_we;
  logic [AW-1:0] idx;
  logic          unused_ctrl;

  // Full 32-bit compare so out-of-range addresses never alias into the array.
  assign in_range    = addr_q < 32'(DEPTH);
  assign idx         = addr_q[AW-1:0];
  assign access      = (state_q == S_WAIT) && (cnt_q == 8'd0);
  assign mem_we      = access && (op_q == OP_WR) && in_range;
  assign unused_ctrl = ^ctrl_in[31:2];

  always_comb begin
    op_d = OP_NONE;
    case (ctrl_in[1:0])
      2'b01:   op_d = OP_RD;
      2'b10:   op_d = OP_WR;
      2'b11:   op_d = OP_ERR;
      default: op_d = OP_NONE;
    endcase
  end

  // Array is not reset; a reset forces IDLE so a pending write can never fire.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      cnt_q     <= 8'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      rd_data_q <= 32'd0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_d != OP_NONE) begin
            addr_q  <= addr;
            data_q  <= wr_data;
            op_q    <= op_d;
            cnt_q   <= 8'(WAIT_CYCLES);
            ready_q <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            done_q  <= 1'b1;
            err_q   <= (op_q == OP_ERR) || !in_range;
            state_q <= S_DONE;
            if (op_q == OP_RD) begin
              rd_data_q <= in_range ? mem[idx] : 32'd0;
            end else if (op_q == OP_ERR) begin
              rd_data_q <= 32'd0;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ctrl_out = {29'd0, err_q, done_q, ready_q};
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Randomised scoreboard bench for ram_ctrl: stimulus pushes expected done responses, a monitor pops on each done.
module tb_ram_ctrl;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ctrl_in = 32'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] ctrl_out;
  logic [31:0] rd_data;

  logic [31:0] c0_in = 32'd0;
  logic [31:0] a0 = 32'd0;
  logic [31:0] d0 = 32'd0;
  logic [31:0] c0_out;
  logic [31:0] r0;

  ram_ctrl #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .ctrl_out(ctrl_out),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
  );

  ram_ctrl #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ctrl_in(c0_in), .ctrl_out(c0_out),
    .addr(a0), .wr_data(d0), .rd_data(r0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_mem [logic [31:0]];
  logic [31:0] m_rd = 32'd0;
  bit          chained = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference behaviour: one transaction at a time, applied in issue order.
  function automatic void model_push(input logic rd, input logic wr, input logic [31:0] a,
                                     input logic [31:0] d, input int done_cyc);
    exp_t e;
    e.cyc = done_cyc;
    e.err = (rd && wr) || (a >= 32'd1024);
    if (rd && wr) m_rd = 32'd0;
    else if (rd) m_rd = e.err ? 32'd0 : m_mem[a];
    else if (!e.err) m_mem[a] = d;
    e.rd = m_rd;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && ctrl_out[1]) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending transaction", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("err", {31'd0, ctrl_out[2]}, {31'd0, mon_e.err});
        check("rd_data", rd_data, mon_e.rd);
        check("ready_in_done", {31'd0, ctrl_out[0]}, 32'd0);
        check("status_upper", {3'd0, ctrl_out[31:3]}, 32'd0);
      end
    end
  end

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input bit hold);
    int lead;
    bit got;
    lead = chained ? 2 : 1;
    ctrl_in = {30'd0, wr, rd};
    addr    = a;
    wr_data = d;
    model_push(rd, wr, a, d, cyc + lead + WC + 1);
    repeat (lead) @(negedge clk);
    check("ready_low_after_accept", {31'd0, ctrl_out[0]}, 32'd0);
    addr    = $urandom;
    wr_data = $urandom;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ctrl_out[1]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within 400 cycles, expected done at %0d", cyc);
    end
    chained = hold;
    if (!hold) begin
      ctrl_in = 32'd0;
      @(negedge clk);
      check("ready_back_in_idle", {31'd0, ctrl_out[0]}, 32'd1);
    end
  endtask

  task automatic wait0(output int at, output bit got);
    got = 1'b0;
    at  = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (c0_out[1]) begin
        got = 1'b1;
        at  = cyc;
        break;
      end
    end
  endtask

  initial begin
    int          n;
    int          at;
    bit          got;
    int          sel;
    logic [31:0] ra;
    logic        hold;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl_out", ctrl_out, 32'h0000_0001);
    check("reset_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    txn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
    txn(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      if (i != 5) txn(1'b0, 1'b1, i, (i == 7) ? 32'hAAAA_AAAA : $urandom, 1'b0);
    end

    txn(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
    txn(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);

    txn(1'b1, 1'b1, 32'd3, 32'h0000_1234, 1'b0);
    txn(1'b1, 1'b0, 32'd3, 32'd0, 1'b0);

    txn(1'b0, 1'b1, 32'd1, 32'h0000_0010, 1'b1);
    txn(1'b1, 1'b0, 32'd1, 32'd0, 1'b0);

    // Abort a write to addr 7 while it is waiting.
    ctrl_in = 32'd2;
    addr    = 32'd7;
    wr_data = 32'h5555_5555;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    ctrl_in = 32'd0;
    #1;
    check("midreset_ctrl_out", ctrl_out, 32'h0000_0001);
    check("midreset_rd_data", rd_data, 32'd0);
    m_rd = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chained = 1'b0;
    txn(1'b1, 1'b0, 32'd7, 32'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       ra = 32'd1024 + $urandom_range(0, 15);
        1:       ra = 32'h0001_0000 + $urandom_range(0, 15);
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom_range(0, 15);
      endcase
      hold = ($urandom_range(0, 2) == 0) && (i < 39);
      sel  = $urandom_range(0, 8);
      if (sel < 4)      txn(1'b1, 1'b0, ra, 32'd0, hold);
      else if (sel < 8) txn(1'b0, 1'b1, ra, $urandom, hold);
      else              txn(1'b1, 1'b1, ra, $urandom, hold);
    end

    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", sb.size(), 32'd0);

    // Zero-wait-state instance.
    c0_in = 32'd2;
    a0    = 32'd2;
    d0    = 32'hCAFE_0002;
    n     = cyc;
    wait0(at, got);
    check("wc0_write_latency", at, n + 2);
    check("wc0_write_err", {31'd0, c0_out[2]}, 32'd0);
    c0_in = 32'd0;
    @(negedge clk);
    c0_in = 32'd1;
    a0    = 32'd2;
    n     = cyc;
    wait0(at, got);
    check("wc0_read_latency", at, n + 2);
    check("wc0_read_data", r0, 32'hCAFE_0002);
    c0_in = 32'd0;
    @(negedge clk);
    check("wc0_ready_idle", c0_out, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
